// File: rtl/sudoku_cell_picker.sv
// rtl/sudoku_cell_picker.sv - rejection-samples RNG nibbles into unique Sudoku givens
// All state advances on the falling edge of clka; outputs are decoded from registers only.
module sudoku_cell_picker #(
  parameter int NUM_CELLS = 17,
  parameter int RAND_LAT  = 2,
  parameter int MAX_TRIES = 15
) (
  input  logic       clka,
  input  logic       restart_n,
  input  logic       start,
  output logic       gen_rand_flag,
  input  logic [3:0] rand_setup,
  input  logic [3:0] rand_A,
  input  logic [3:0] rand_B,
  output logic       cell_valid,
  input  logic       cell_ready,
  output logic [3:0] cell_row,
  output logic [3:0] cell_col,
  output logic [3:0] cell_val,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] reject_total
);

  localparam int WW = $clog2(RAND_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_CHECK, S_EMIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]    cap_setup_q, cap_setup_d;
  logic [3:0]    cap_a_q, cap_a_d;
  logic [3:0]    cap_b_q, cap_b_d;
  logic [80:0]   occ_q, occ_d;
  logic [6:0]    count_q, count_d;
  logic [7:0]    tries_q, tries_d;
  logic          err_q, err_d;
  logic [7:0]    reject_q, reject_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    val_q, val_d;

  logic          in_range;
  logic [6:0]    idx;
  logic          accept;

  // Index is forced to zero unless the nibbles are in range, so stray values never address occ_q.
  always_comb begin
    in_range = (cap_a_q <= 4'd8) && (cap_b_q <= 4'd8) &&
               (cap_setup_q >= 4'd1) && (cap_setup_q <= 4'd9);
    idx      = in_range ? (({3'b000, cap_a_q} * 7'd9) + {3'b000, cap_b_q}) : 7'd0;
    accept   = in_range && !occ_q[idx];
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    cap_setup_d = cap_setup_q;
    cap_a_d     = cap_a_q;
    cap_b_d     = cap_b_q;
    occ_d       = occ_q;
    count_d     = count_q;
    tries_d     = tries_q;
    err_d       = err_q;
    reject_d    = reject_q;
    row_d       = row_q;
    col_d       = col_q;
    val_d       = val_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          occ_d    = '0;
          count_d  = '0;
          tries_d  = '0;
          err_d    = 1'b0;
          reject_d = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WW'(RAND_LAT - 1)) begin
          cap_setup_d = rand_setup;
          cap_a_d     = rand_A;
          cap_b_d     = rand_B;
          state_d     = S_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (accept) begin
          row_d        = cap_a_q;
          col_d        = cap_b_q;
          val_d        = cap_setup_q;
          occ_d[idx]   = 1'b1;
          count_d      = count_q + 7'd1;
          tries_d      = '0;
          state_d      = S_EMIT;
        end else begin
          if (reject_q != 8'hff) reject_d = reject_q + 8'd1;
          tries_d = tries_q + 8'd1;
          if (tries_q + 8'd1 == 8'(MAX_TRIES)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_EMIT: begin
        if (cell_ready) state_d = (count_q == 7'(NUM_CELLS)) ? S_DONE : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      cap_setup_q <= '0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      occ_q       <= '0;
      count_q     <= '0;
      tries_q     <= '0;
      err_q       <= 1'b0;
      reject_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      val_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      cap_setup_q <= cap_setup_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      occ_q       <= occ_d;
      count_q     <= count_d;
      tries_q     <= tries_d;
      err_q       <= err_d;
      reject_q    <= reject_d;
      row_q       <= row_d;
      col_q       <= col_d;
      val_q       <= val_d;
    end
  end

  assign gen_rand_flag = (state_q == S_REQ);
  assign cell_valid    = (state_q == S_EMIT);
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign reject_total  = reject_q;
  assign cell_row      = row_q;
  assign cell_col      = col_q;
  assign cell_val      = val_q;

endmodule

// File: doc/sudoku_cell_picker.md
Name: sudoku_cell_picker

Overview:
- Consumer end of the random-number interface: requests values from lfsr_rng via gen_rand_flag and reads back rand_setup/rand_A/rand_B.
- Rejection-samples the returned nibbles into unique Sudoku givens (row, col, value), tracking occupied cells in an 81-bit bitmap.
- Delivers each accepted given downstream on a valid/ready handshake until NUM_CELLS givens are produced or the retry budget runs out.
- Sits between the RNG and the board-setup datapath.

Parameters:
NUM_CELLS, 17, givens to produce per run (1..81)
RAND_LAT, 2, clock edges from the gen_rand_flag request to stable rand_* inputs (>=1)
MAX_TRIES, 15, consecutive rejects allowed for one cell before abort (1..255)

Ports:
clka  in  1  single clock; all state updates on its falling edge
restart_n  in  1  asynchronous active-low reset
start  in  1  begin a run; honoured only in IDLE or DONE
gen_rand_flag  out  1  one-cycle request pulse to RNG
rand_setup  in  4  candidate value
rand_A  in  4  candidate row
rand_B  in  4  candidate column
cell_valid  out  1  given available
cell_ready  in  1  downstream accepts given
cell_row  out  4  row 0..8
cell_col  out  4  column 0..8
cell_val  out  4  value 1..9
busy  out  1  high in every state except IDLE and DONE
done  out  1  run finished; held until next start or reset
err  out  1  run aborted on retry limit; valid while done=1
reject_total  out  8  rejects this run, saturating at 255

Behaviour:
- Reset (async, restart_n=0): state IDLE; all outputs 0; occupancy bitmap, cell count and try counter cleared. Takes effect immediately; cell_valid drops mid-handshake and no pending given is retained.
- States: IDLE, REQ, WAIT, CHECK, EMIT, DONE.
- IDLE/DONE: start=1 at an edge clears bitmap, count, tries, err and reject_total, drops done, and moves to REQ. start is ignored in all other states.
- REQ: gen_rand_flag=1 for exactly this one cycle, then WAIT.
- WAIT: stays RAND_LAT edges. rand_setup/A/B are captured into internal registers at the final WAIT edge, then CHECK.
- CHECK (one cycle), accept iff all hold:
  - rand_A<=8
  - rand_B<=8
  - 1<=rand_setup<=9
  - bitmap[rand_A*9+rand_B]==0
- Index arithmetic is 7-bit unsigned and computed only after the range checks pass; out-of-range nibbles never index the bitmap.
- Accept: load cell_row/col/val, set the bitmap bit, count+1, tries=0, go to EMIT.
- Reject: reject_total+1 (saturating), tries+1. If tries reaches MAX_TRIES, go to DONE with err=1; otherwise go to REQ.
- EMIT: cell_valid=1. cell_row/col/val are held stable until the cycle where cell_valid&&cell_ready. No gen_rand_flag is issued while in EMIT.
- On the handshake: cell_valid clears at that edge; go to DONE (err=0) if count==NUM_CELLS, else REQ.
- Outputs are registered; no combinational path from cell_ready to cell_valid.
- Latency: cell_valid rises RAND_LAT+2 edges after gen_rand_flag rises, for an accepted first try.
- DONE: done=1, busy=0. cell_row/col/val keep their last values; cell_valid=0.
- Count width is 7 bits. Uniqueness guarantees a run never requests more than 81 positions.

Test Plan:
- Reset, start; RNG model returns setup=5,A=2,B=3 -> one gen_rand_flag pulse; cell_valid after 4 edges; row=2,col=3,val=5; reject_total=0.
- Returns A=9, then setup=0, then setup=10, then valid (7,8,9) -> three extra gen_rand_flag pulses; reject_total=3; given row=7,col=8,val=9.
- Same position (2,3) returned twice -> second rejected; next distinct position accepted; no duplicate given emitted.
- cell_ready held low 6 cycles during EMIT -> cell_valid and data stable; gen_rand_flag stays 0; one handshake on ready.
- NUM_CELLS=3 with always-valid distinct values -> exactly 3 handshakes, then done=1, err=0, busy=0; start ignored mid-run.
- RNG stuck at A=15 with MAX_TRIES=4 -> 4 requests, then done=1, err=1, reject_total=4. Then assert restart_n=0 while cell_valid=1 in a later run -> all outputs 0 immediately, state IDLE.
